// File: rtl/adc_conv_sequencer.sv
// adc_conv_sequencer
//   Sits directly behind the ADC. It issues the start_conversion pulse, waits
//   for conversion_finished (synchronised here), captures the 16-bit result
//   into a show-ahead FIFO and presents it to a system-side reader. It supports
//   single-shot and periodic (continuous) operation, a finish timeout and
//   sticky overflow/timeout flags.
//
// Ports
//   clk, rst_n             system clock, synchronous active-low reset
//   enable_in              sequencer enable
//   continuous_in          1 = periodic conversions, 0 = single-shot
//   single_trig_in         one-cycle request for one conversion
//   period_in              idle cycles between capture and next start
//   start_conversion_out   start pulse to the ADC (START_CYCLES long)
//   conv_finished_in       ADC conversion_finished (asynchronous)
//   result_in              ADC result, stable while finished is high
//   fifo_rd_in             pop head entry
//   fifo_data_out          head entry (valid when !fifo_empty_out)
//   fifo_empty_out/full    FIFO status
//   fifo_level_out         entry count
//   overflow_out           sticky: result dropped, FIFO full
//   timeout_out            sticky: finish not seen in time
//   clear_flags_in         clears both sticky flags
//   busy_out               high whenever the FSM is not idle
module adc_conv_sequencer #(
  parameter int FIFO_DEPTH     = 8,
  parameter int PERIOD_W       = 16,
  parameter int START_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable_in,
  input  logic                          continuous_in,
  input  logic                          single_trig_in,
  input  logic [PERIOD_W-1:0]           period_in,
  output logic                          start_conversion_out,
  input  logic                          conv_finished_in,
  input  logic [15:0]                   result_in,
  input  logic                          fifo_rd_in,
  output logic [15:0]                   fifo_data_out,
  output logic                          fifo_empty_out,
  output logic                          fifo_full_out,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_out,
  output logic                          overflow_out,
  output logic                          timeout_out,
  input  logic                          clear_flags_in,
  output logic                          busy_out
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int LW  = AW + 1;
  localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int SW  = $clog2(START_CYCLES + 1);
  localparam int CW0 = (PERIOD_W > TW) ? PERIOD_W : TW;
  // One shared counter covers the start pulse, the timeout and the holdoff.
  localparam int CW  = (CW0 > SW) ? CW0 : SW;

  typedef enum logic [2:0] {
    ST_IDLE, ST_START, ST_WAIT, ST_CAPTURE, ST_HOLD
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic            r_start;
  logic            r_busy;
  logic            r_overflow;
  logic            r_timeout;

  // finished synchroniser: two flops plus an edge register
  logic            r_fin_s1, r_fin_s2, r_fin_d;
  logic            w_fin_rise;

  // FIFO state
  logic [15:0]     r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wr_ptr, r_rd_ptr;
  logic [LW-1:0]   r_level;
  logic [LW-1:0]   w_level_nxt;
  logic            r_empty, r_full;
  logic            w_wr, w_rd;
  logic            w_set_ov, w_set_to;

  assign w_fin_rise = r_fin_s2 & ~r_fin_d;

  // A rise in the same cycle as the last timeout count takes priority.
  assign w_set_to = (r_state == ST_WAIT) && !w_fin_rise &&
                    (r_cnt == CW'(TIMEOUT_CYCLES - 1));

  // A read in the capture cycle frees a slot, so a full FIFO still accepts.
  assign w_wr     = (r_state == ST_CAPTURE) && (!r_full || fifo_rd_in);
  assign w_set_ov = (r_state == ST_CAPTURE) && r_full && !fifo_rd_in;
  assign w_rd     = fifo_rd_in && !r_empty;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_start    <= 1'b0;
      r_busy     <= 1'b0;
      r_overflow <= 1'b0;
      r_timeout  <= 1'b0;
      r_fin_s1   <= 1'b0;
      r_fin_s2   <= 1'b0;
      r_fin_d    <= 1'b0;
    end else begin
      r_fin_s1 <= conv_finished_in;
      r_fin_s2 <= r_fin_s1;
      r_fin_d  <= r_fin_s2;

      case (r_state)
        ST_IDLE: begin
          if (enable_in && (single_trig_in || continuous_in)) begin
            r_state <= ST_START;
            r_cnt   <= CW'(START_CYCLES);
            r_start <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        ST_START: begin
          if (r_cnt <= CW'(1)) begin
            r_state <= ST_WAIT;
            r_cnt   <= '0;
            r_start <= 1'b0;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        ST_WAIT: begin
          // Edge detect: a finished level already high at start is ignored.
          if (w_fin_rise) begin
            r_state <= ST_CAPTURE;
          end else if (w_set_to) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        ST_CAPTURE: begin
          // result_in is sampled directly: it has been stable for the whole
          // synchroniser latency, so no second capture register is needed.
          if (enable_in && continuous_in) begin
            r_state <= ST_HOLD;
            r_cnt   <= CW'(period_in);
          end else begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        ST_HOLD: begin
          if (!enable_in || !continuous_in) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else if (r_cnt == '0) begin
            r_state <= ST_START;
            r_cnt   <= CW'(START_CYCLES);
            r_start <= 1'b1;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_start <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase

      // Sticky flags: a set event beats a simultaneous clear.
      if (w_set_ov)            r_overflow <= 1'b1;
      else if (clear_flags_in) r_overflow <= 1'b0;
      if (w_set_to)            r_timeout  <= 1'b1;
      else if (clear_flags_in) r_timeout  <= 1'b0;
    end
  end

  always_comb begin
    w_level_nxt = r_level;
    if (w_wr && !w_rd)      w_level_nxt = r_level + LW'(1);
    else if (w_rd && !w_wr) w_level_nxt = r_level - LW'(1);
  end

  // Depth is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_empty  <= 1'b1;
      r_full   <= 1'b0;
    end else begin
      if (w_wr) begin
        r_mem[r_wr_ptr] <= result_in;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_level <= w_level_nxt;
      r_empty <= (w_level_nxt == '0);
      r_full  <= (w_level_nxt == LW'(FIFO_DEPTH));
    end
  end

  assign start_conversion_out = r_start;
  assign busy_out             = r_busy;
  assign overflow_out         = r_overflow;
  assign timeout_out          = r_timeout;
  assign fifo_data_out        = r_mem[r_rd_ptr];
  assign fifo_empty_out       = r_empty;
  assign fifo_full_out        = r_full;
  assign fifo_level_out       = r_level;

endmodule
